// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - gate modes, sweep FSM encodings and per-lane golden gate model
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        MODE_AND    = 3'd0,
        MODE_OR     = 3'd1,
        MODE_XOR    = 3'd2,
        MODE_XNOR   = 3'd3,
        MODE_BUFIF0 = 3'd4,
        MODE_NOTIF1 = 3'd5
    } gate_mode_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Codes 6 and 7 have no gate behind them; a start carrying them is dropped.
    function automatic logic mode_is_legal(input logic [2:0] m);
        return m <= 3'd5;
    endfunction

    // Expected {y, oe} for one lane. Tri-state modes express high-Z as oe=0.
    function automatic logic [1:0] golden_lane(input gate_mode_e m, input logic a, input logic b);
        case (m)
            MODE_AND:    return {a & b, 1'b1};
            MODE_OR:     return {a | b, 1'b1};
            MODE_XOR:    return {a ^ b, 1'b1};
            MODE_XNOR:   return {~(a ^ b), 1'b1};
            MODE_BUFIF0: return {a, ~b};
            MODE_NOTIF1: return {~a, b};
            default:     return {1'b0, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/sweep_delay_line.sv
// rtl/sweep_delay_line.sv - LAT-deep register pipe aligning expected results with DUT responses
module sweep_delay_line #(
    parameter int LAT = 1,
    parameter int DW  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data
);

    generate
        if (LAT == 0) begin : g_wire
            assign out_data = in_data;
        end else begin : g_pipe
            logic [DW-1:0] stage [LAT];

            // Shift one stage per clock; reset empties the pipe so no stale valid survives an abort.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LAT; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= in_data;
                    for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
                end
            end

            assign out_data = stage[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive truth-table sweep of a 2-input gate bank against a golden model
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int W    = 4,
    parameter int LAT  = 1,
    parameter int ERRW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [W-1:0]    a_out,
    output logic [W-1:0]    b_out,
    input  logic [W-1:0]    dut_y,
    input  logic [W-1:0]    dut_oe,
    output logic [ERRW-1:0] err_cnt,
    output logic            first_fail_valid,
    output logic [2*W-1:0]  first_fail_vec
);

    localparam int VW = 2 * W;
    localparam int DW = 1 + VW + 2 * W;

    logic [1:0]      state;
    logic [VW-1:0]   vec;
    gate_mode_e      mode_q;
    logic [2:0]      drain_cnt;
    logic [W-1:0]    exp_y;
    logic [W-1:0]    exp_oe;
    logic [DW-1:0]   pipe_in;
    logic [DW-1:0]   pipe_out;
    logic            chk_valid;
    logic [VW-1:0]   chk_tag;
    logic [W-1:0]    chk_y;
    logic [W-1:0]    chk_oe;
    logic            vec_fail;
    logic [ERRW-1:0] err_next;
    logic            accept;
    logic            to_done;

    assign a_out = vec[VW-1:W];
    assign b_out = vec[W-1:0];
    assign busy  = (state == ST_RUN) || (state == ST_DRAIN);
    assign done  = (state == ST_DONE);

    // Golden response for the vector currently on a_out/b_out.
    always_comb begin
        exp_y  = '0;
        exp_oe = '0;
        for (int i = 0; i < W; i++) begin
            {exp_y[i], exp_oe[i]} = golden_lane(mode_q, a_out[i], b_out[i]);
        end
    end

    assign pipe_in = {state == ST_RUN, vec, exp_y, exp_oe};

    sweep_delay_line #(
        .LAT (LAT),
        .DW  (DW)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in_data  (pipe_in),
        .out_data (pipe_out)
    );

    assign {chk_valid, chk_tag, chk_y, chk_oe} = pipe_out;

    // y is only judged on lanes that are expected to drive.
    assign vec_fail = chk_valid && (|((dut_oe ^ chk_oe) | (chk_oe & (dut_y ^ chk_y))));
    assign err_next = (vec_fail && (err_cnt != '1)) ? err_cnt + ERRW'(1) : err_cnt;
    assign accept   = ((state == ST_IDLE) || (state == ST_DONE)) && start && mode_is_legal(mode);
    assign to_done  = ((state == ST_RUN) && (vec == '1) && (LAT == 0)) ||
                      ((state == ST_DRAIN) && (drain_cnt == 3'(LAT - 1)));

    // Sweep sequencing: walk every {a,b}, then wait out the DUT latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            vec       <= '0;
            mode_q    <= MODE_AND;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state  <= ST_RUN;
                        vec    <= '0;
                        mode_q <= gate_mode_e'(mode);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (vec == '1) begin
                        state     <= (LAT == 0) ? ST_DONE : ST_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        vec <= vec + VW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (to_done) state <= ST_DONE;
                    else         drain_cnt <= drain_cnt + 3'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result accounting; pass is decided on the same edge as the final comparison.
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
        end else begin
            err_cnt <= err_next;
            if (vec_fail && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_vec   <= chk_tag;
            end
            if (to_done) pass <= (err_next == '0);
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// tb/tb_gate_sweep_checker.sv - directed bench for gate_sweep_checker across four parameter sets
module tb_gate_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] start_v, busy_v, done_v, pass_v;
    logic [2:0] mode_v [4];

    logic [1:0]  a0, b0, y0, oe0;
    logic [15:0] err0;
    logic        ffv0;
    logic [3:0]  ffvec0;

    logic [1:0]  a1, b1, y1, oe1;
    logic [15:0] err1;
    logic        ffv1;
    logic [3:0]  ffvec1;

    logic [1:0]  a2, b2, y2, oe2;
    logic [1:0]  err2;
    logic        ffv2;
    logic [3:0]  ffvec2;

    logic [2:0]  a3, b3, y3, oe3;
    logic [15:0] err3;
    logic        ffv3;
    logic [5:0]  ffvec3;

    gate_sweep_checker #(.W(2), .LAT(1), .ERRW(16)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .a_out(a0), .b_out(b0), .dut_y(y0), .dut_oe(oe0),
        .err_cnt(err0), .first_fail_valid(ffv0), .first_fail_vec(ffvec0));

    gate_sweep_checker #(.W(2), .LAT(0), .ERRW(16)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .a_out(a1), .b_out(b1), .dut_y(y1), .dut_oe(oe1),
        .err_cnt(err1), .first_fail_valid(ffv1), .first_fail_vec(ffvec1));

    gate_sweep_checker #(.W(2), .LAT(1), .ERRW(2)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .a_out(a2), .b_out(b2), .dut_y(y2), .dut_oe(oe2),
        .err_cnt(err2), .first_fail_valid(ffv2), .first_fail_vec(ffvec2));

    gate_sweep_checker #(.W(3), .LAT(4), .ERRW(16)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode_v[3]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
        .a_out(a3), .b_out(b3), .dut_y(y3), .dut_oe(oe3),
        .err_cnt(err3), .first_fail_valid(ffv3), .first_fail_vec(ffvec3));

    // Gate banks under test
    logic       stuck0, good1;
    logic [1:0] y0_q, noise1;
    logic [2:0] p3 [4];

    always @(posedge clk) y0_q <= a0 & b0;
    assign y0  = stuck0 ? (y0_q | 2'b01) : y0_q;
    assign oe0 = 2'b11;

    always @(negedge clk) noise1 <= 2'($urandom);
    assign oe1 = good1 ? ~b1 : 2'b11;
    assign y1  = good1 ? ((a1 & ~b1) | (noise1 & b1)) : 2'b00;

    assign y2  = 2'b00;
    assign oe2 = 2'b11;

    always @(posedge clk) begin
        p3[0] <= ~(a3 ^ b3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        p3[3] <= p3[2];
    end
    assign y3  = p3[3];
    assign oe3 = 3'b111;

    int n_vec = 0;
    int n_bad = 0;
    int t;
    int n_done;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic kick(input int idx, input logic [2:0] m);
        mode_v[idx]  = m;
        start_v[idx] = 1'b1;
        @(negedge clk);
        start_v[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int poke_at, output int tt);
        tt = 0;
        while (done_v[idx] !== 1'b1 && tt < 300) begin
            start_v[idx] = (tt == poke_at);
            @(negedge clk);
            tt++;
        end
        start_v[idx] = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start_v = '0;
        stuck0  = 1'b0;
        good1   = 1'b0;
        for (int i = 0; i < 4; i++) mode_v[i] = 3'd0;
        repeat (3) @(negedge clk);

        check_val("rst_busy",   busy_v[0], 0);
        check_val("rst_done",   done_v[0], 0);
        check_val("rst_pass",   pass_v[0], 0);
        check_val("rst_a",      a0, 0);
        check_val("rst_b",      b0, 0);
        check_val("rst_err",    err0, 0);
        check_val("rst_ffv",    ffv0, 0);
        check_val("rst_ffvec",  ffvec0, 0);
        rst = 1'b0;
        @(negedge clk);

        // AND, correct DUT
        kick(0, 3'd0);
        check_val("and_busy0", busy_v[0], 1);
        check_val("and_vec0",  {a0, b0}, 0);
        wait_done(0, -1, t);
        check_val("and_done_t", t, 17);
        check_val("and_err",    err0, 0);
        check_val("and_pass",   pass_v[0], 1);
        check_val("and_ffv",    ffv0, 0);
        check_val("and_busy_d", busy_v[0], 0);
        @(negedge clk);
        check_val("and_done_pulse", done_v[0], 0);
        check_val("and_pass_hold",  pass_v[0], 1);

        // AND, lane 0 stuck at 1
        stuck0 = 1'b1;
        kick(0, 3'd0);
        check_val("stk_pass_clr", pass_v[0], 0);
        wait_done(0, -1, t);
        check_val("stk_done_t", t, 17);
        check_val("stk_err",    err0, 12);
        check_val("stk_ffv",    ffv0, 1);
        check_val("stk_ffvec",  ffvec0, 4'b0000);
        check_val("stk_pass",   pass_v[0], 0);

        // Illegal mode is ignored and clears nothing
        kick(0, 3'd6);
        check_val("ill_busy", busy_v[0], 0);
        check_val("ill_err",  err0, 12);

        // NOTIF1 sweep aborted by reset at E0+5
        kick(0, 3'd5);
        repeat (4) @(negedge clk);
        check_val("abt_err_pre", err0, 3);
        rst = 1'b1;
        @(negedge clk);
        check_val("abt_busy",  busy_v[0], 0);
        check_val("abt_done",  done_v[0], 0);
        check_val("abt_pass",  pass_v[0], 0);
        check_val("abt_ab",    {a0, b0}, 0);
        check_val("abt_err",   err0, 0);
        check_val("abt_ffv",   ffv0, 0);
        check_val("abt_ffvec", ffvec0, 0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_v[0] === 1'b1) n_done++;
        end
        check_val("abt_no_done", n_done, 0);

        // BUFIF0, LAT=0, DUT drives every lane low
        kick(1, 3'd4);
        wait_done(1, -1, t);
        check_val("bz_done_t", t, 16);
        check_val("bz_err",    err1, 15);
        check_val("bz_ffvec",  ffvec1, 4'b0001);
        check_val("bz_pass",   pass_v[1], 0);
        good1 = 1'b1;
        kick(1, 3'd4);
        wait_done(1, -1, t);
        check_val("bz_good_t",    t, 16);
        check_val("bz_good_err",  err1, 0);
        check_val("bz_good_pass", pass_v[1], 1);

        // XOR with 2-bit counter, start pulsed mid-sweep
        kick(2, 3'd2);
        wait_done(2, 8, t);
        check_val("sat_done_t", t, 17);
        check_val("sat_err",    err2, 3);
        check_val("sat_ffvec",  ffvec2, 4'b0001);
        check_val("sat_pass",   pass_v[2], 0);

        // XNOR, W=3, LAT=4, then back-to-back restart in the done cycle
        kick(3, 3'd3);
        wait_done(3, -1, t);
        check_val("lat4_done_t", t, 68);
        check_val("lat4_err",    err3, 0);
        check_val("lat4_pass",   pass_v[3], 1);
        kick(3, 3'd3);
        check_val("b2b_busy", busy_v[3], 1);
        check_val("b2b_vec0", {a3, b3}, 0);
        check_val("b2b_pass", pass_v[3], 0);
        check_val("b2b_err",  err3, 0);
        wait_done(3, -1, t);
        check_val("b2b_done_t", t, 68);
        check_val("b2b_pass2",  pass_v[3], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
